// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    // Sequencer life cycle: waiting for launch, fetching, stopped.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int PC_W = 12;

    // Entry addresses selected by prog_sel on launch.
    localparam logic [PC_W-1:0] PROG0_START = 12'h000;
    localparam logic [PC_W-1:0] PROG1_START = 12'h100;
    localparam logic [PC_W-1:0] PROG2_START = 12'h200;
    localparam logic [PC_W-1:0] PROG3_START = 12'h000;

    // Map a program select code to its entry address.
    function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] sel);
        case (sel)
            2'd1:    return PROG1_START;
            2'd2:    return PROG2_START;
            2'd3:    return PROG3_START;
            default: return PROG0_START;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic             at_max;

    assign at_max = &count_reg;
    assign count  = count_reg;

    // Clear wins over enable; once all-ones the counter sticks there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !at_max) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: launches at an entry address, advances by one or by
// a signed branch offset each cycle, stops on halt or watchdog expiry.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               D          = 12,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'hFFF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             branch_en,
    input  logic             branch_taken,
    input  logic [D-1:0]     offset,
    input  logic             halt,
    output logic [D-1:0]     prog_ctr,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    pc_state_t        state_reg;
    pc_state_t        state_next;
    logic [D-1:0]     pc_reg;
    logic [D-1:0]     pc_next;
    logic             timeout_reg;
    logic             timeout_next;

    logic             cnt_clr;
    logic             cnt_en;
    logic             wd_clr;
    logic             wd_en;
    logic [CNT_W-1:0] wd_count;
    logic             wd_fire;

    // Watchdog expires on the edge where it has already seen MAX_CYCLES-1 RUN cycles.
    assign wd_fire = (wd_count == (MAX_CYCLES - CNT_W'(1)));

    // Retired-instruction counter: every RUN cycle retires one instruction,
    // including the halting one and the one cut off by the watchdog.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (instr_count)
    );

    // Watchdog: counts RUN cycles since the last launch.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .count (wd_count)
    );

    // State, PC and timeout flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state, next-PC and counter controls; halt outranks the watchdog,
    // which outranks branching.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        timeout_next = timeout_reg;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = RUN;
                    pc_next      = D'(entry_addr(prog_sel));
                    timeout_next = 1'b0;
                    cnt_clr      = 1'b1;
                    wd_clr       = 1'b1;
                end
            end

            RUN: begin
                cnt_en = 1'b1;
                wd_en  = 1'b1;
                if (halt) begin
                    state_next = DONE;
                end else if (wd_fire) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end else if (branch_en && branch_taken) begin
                    // Offset is already sign-extended; wrap modulo 2^D.
                    pc_next = pc_reg + offset;
                end else begin
                    pc_next = pc_reg + D'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign prog_ctr = pc_reg;
    assign running  = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model.
module tb_pc_sequencer;

    localparam int MAX    = 16;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        start        = 1'b0;
    logic [1:0]  prog_sel     = 2'd0;
    logic        branch_en    = 1'b0;
    logic        branch_taken = 1'b0;
    logic [11:0] offset       = 12'h000;
    logic        halt         = 1'b0;

    logic [11:0] prog_ctr;
    logic        running;
    logic        done;
    logic        timeout;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_steps  = 0;

    // Reference model state
    int m_state = S_IDLE;
    int m_pc    = 0;
    int m_cnt   = 0;
    int m_wd    = 0;
    bit m_to    = 1'b0;

    pc_sequencer #(
        .D          (12),
        .CNT_W      (16),
        .MAX_CYCLES (16'd16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_sel     (prog_sel),
        .branch_en    (branch_en),
        .branch_taken (branch_taken),
        .offset       (offset),
        .halt         (halt),
        .prog_ctr     (prog_ctr),
        .running      (running),
        .done         (done),
        .timeout      (timeout),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    function automatic int entry(input int sel);
        case (sel)
            1:       return 'h100;
            2:       return 'h200;
            default: return 0;
        endcase
    endfunction

    function automatic int soff(input logic [11:0] off);
        return off[11] ? int'(off) - 4096 : int'(off);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: apply the sequencing rules to the inputs seen at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= S_IDLE;
            m_pc    <= 0;
            m_cnt   <= 0;
            m_wd    <= 0;
            m_to    <= 1'b0;
        end else if (m_state != S_RUN) begin
            if (start) begin
                m_state <= S_RUN;
                m_pc    <= entry(int'(prog_sel));
                m_cnt   <= 0;
                m_wd    <= 0;
                m_to    <= 1'b0;
            end
        end else begin
            m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_wd  <= (m_wd < 65535) ? m_wd + 1 : m_wd;
            if (halt) begin
                m_state <= S_DONE;
            end else if (m_wd == MAX - 1) begin
                m_state <= S_DONE;
                m_to    <= 1'b1;
            end else if (branch_en && branch_taken) begin
                m_pc <= (m_pc + soff(offset) + 4096) % 4096;
            end else begin
                m_pc <= (m_pc + 1) % 4096;
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        check("model_pc",      32'(prog_ctr),    32'(m_pc));
        check("model_running", 32'(running),     32'(m_state == S_RUN));
        check("model_done",    32'(done),        32'(m_state == S_DONE));
        check("model_timeout", 32'(timeout),     32'(m_to));
        check("model_count",   32'(instr_count), 32'(m_cnt));
    end

    task automatic step(input logic st, input logic [1:0] sel, input logic be,
                        input logic bt, input logic [11:0] off, input logic h);
        start        = st;
        prog_sel     = sel;
        branch_en    = be;
        branch_taken = bt;
        offset       = off;
        halt         = h;
        @(posedge clk);
        @(negedge clk);
        n_steps++;
        $display("step %0d: start=%0b sel=%0d br=%0b%0b off=%03h halt=%0b -> pc=%03h run=%0b done=%0b to=%0b cnt=%0d",
                 n_steps, st, sel, be, bt, off, h, prog_ctr, running, done, timeout, instr_count);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_pc",      32'(prog_ctr),    32'h0);
        check("reset_running", 32'(running),     32'h0);
        check("reset_done",    32'(done),        32'h0);
        check("reset_timeout", 32'(timeout),     32'h0);
        check("reset_count",   32'(instr_count), 32'h0);
        reset = 1'b0;

        // Launch program 1 and increment through 100..105
        step(1'b1, 2'd1, 1'b0, 1'b0, 12'h000, 1'b0);
        check("launch_pc",      32'(prog_ctr), 32'h100);
        check("launch_running", 32'(running),  32'h1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0);
            check("incr_pc", 32'(prog_ctr), 32'h100 + 32'(i));
        end
        check("incr_count", 32'(instr_count), 32'd5);

        // Asynchronous reset mid-RUN, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        check("async_pc",      32'(prog_ctr),    32'h0);
        check("async_running", 32'(running),     32'h0);
        check("async_done",    32'(done),        32'h0);
        check("async_count",   32'(instr_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Branch behaviour around 20C
        step(1'b1, 2'd2, 1'b0, 1'b0, 12'h000, 1'b0);
        check("launch2_pc", 32'(prog_ctr), 32'h200);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h00C, 1'b0);
        check("br_fwd_pc", 32'(prog_ctr), 32'h20C);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'hF79, 1'b0);
        check("br_neg_pc", 32'(prog_ctr), 32'h185);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h087, 1'b0);
        check("br_back_pc", 32'(prog_ctr), 32'h20C);
        step(1'b0, 2'd0, 1'b1, 1'b0, 12'h055, 1'b0);
        check("br_not_taken_pc", 32'(prog_ctr), 32'h20D);
        step(1'b0, 2'd0, 1'b0, 1'b1, 12'h055, 1'b0);
        check("taken_no_en_pc", 32'(prog_ctr), 32'h20E);

        // start while running is ignored
        step(1'b1, 2'd1, 1'b0, 1'b0, 12'h000, 1'b0);
        check("start_in_run_pc",    32'(prog_ctr),    32'h20F);
        check("start_in_run_count", 32'(instr_count), 32'd6);

        // Wrap-around at the top and a negative branch below zero
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'hDF0, 1'b0);
        check("to_fff_pc", 32'(prog_ctr), 32'hFFF);
        step(1'b0, 2'd0, 1'b0, 1'b0, 12'h000, 1'b0);
        check("wrap_pc", 32'(prog_ctr), 32'h000);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h005, 1'b0);
        check("to_005_pc", 32'(prog_ctr), 32'h005);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'hFF0, 1'b0);
        check("neg_wrap_pc", 32'(prog_ctr), 32'hFF5);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h0AB, 1'b0);
        check("to_0a0_pc", 32'(prog_ctr), 32'h0A0);

        // Halt beats a simultaneous taken branch
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h005, 1'b1);
        check("halt_done",    32'(done),        32'h1);
        check("halt_running", 32'(running),     32'h0);
        check("halt_pc",      32'(prog_ctr),    32'h0A0);
        check("halt_count",   32'(instr_count), 32'd12);
        check("halt_timeout", 32'(timeout),     32'h0);

        // DONE ignores branch inputs
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h007, 1'b0);
        check("done_hold_pc",    32'(prog_ctr),    32'h0A0);
        check("done_hold_done",  32'(done),        32'h1);
        check("done_hold_count", 32'(instr_count), 32'd12);

        // Relaunch from DONE with prog_sel 3
        step(1'b1, 2'd3, 1'b0, 1'b0, 12'h000, 1'b0);
        check("relaunch_pc",      32'(prog_ctr),    32'h000);
        check("relaunch_running", 32'(running),     32'h1);
        check("relaunch_done",    32'(done),        32'h0);
        check("relaunch_count",   32'(instr_count), 32'd0);

        // Spin loop bounded only by the watchdog
        repeat (15) step(1'b0, 2'd0, 1'b1, 1'b1, 12'h000, 1'b0);
        check("spin_running", 32'(running),     32'h1);
        check("spin_count",   32'(instr_count), 32'd15);
        step(1'b0, 2'd0, 1'b1, 1'b1, 12'h000, 1'b0);
        check("wd_done",    32'(done),        32'h1);
        check("wd_timeout", 32'(timeout),     32'h1);
        check("wd_count",   32'(instr_count), 32'd16);
        check("wd_pc",      32'(prog_ctr),    32'h000);

        // Relaunch clears timeout; immediate halt retires one instruction
        step(1'b1, 2'd2, 1'b0, 1'b0, 12'h000, 1'b0);
        check("relaunch2_timeout", 32'(timeout),  32'h0);
        check("relaunch2_pc",      32'(prog_ctr), 32'h200);
        step(1'b0, 2'd0, 1'b0, 1'b0, 12'h000, 1'b1);
        check("halt1_done",  32'(done),        32'h1);
        check("halt1_count", 32'(instr_count), 32'd1);
        check("halt1_pc",    32'(prog_ctr),    32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
